// File: rtl/uram_stream_reader_if.sv
// Burst command, memory read port and output stream of the URAM stream reader.
// The reader sits on the slave modport; the controller/memory/consumer side uses master.
interface uram_stream_reader_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [ADDRESS_WIDTH:0]   length;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0]    mem_dout;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;

  modport master (
    output start, base_addr, length, mem_dout, out_ready,
    input  busy, done, mem_raddr, out_valid, out_data, out_last
  );

  modport slave (
    input  start, base_addr, length, mem_dout, out_ready,
    output busy, done, mem_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/uram_stream_reader.sv
// Streams a burst of words out of a 1-cycle-latency memory into a ready/valid port,
// using a 2-entry skid FIFO so reads are never issued beyond what can be stored.
module uram_stream_reader #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
) (
  input logic                  clock,
  input logic                  reset,
  uram_stream_reader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] raddr_hold;
  logic [ADDRESS_WIDTH:0]   remaining;
  logic                     inflight;
  logic                     inflight_last;
  logic [DATA_WIDTH-1:0]    fifo_data [2];
  logic [1:0]               fifo_last;
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               fifo_count;
  logic                     done_q;
  logic                     issue, final_issue, push, pop;
  logic                     accept_start, zero_start;
  logic [2:0]               occupancy;

  assign push          = inflight;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight};
  assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid && fifo_last[rd_ptr];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  // Between issues the address is held, so the memory's extra reads are simply never pushed.
  assign bus.mem_raddr = issue ? addr : raddr_hold;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    final_issue  = 1'b0;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            accept_start = 1'b1;
            state_next   = RUN;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      RUN: begin
        // Issue only if the word can be stored after this cycle's pop: FIFO + in-flight < 2.
        issue       = (remaining != '0) && (occupancy < (3'd2 + {2'b00, pop}));
        final_issue = issue && (remaining == (ADDRESS_WIDTH+1)'(1));
        if (final_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_last[rd_ptr]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: issued address becomes an in-flight read
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr          <= '0;
      raddr_hold    <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= zero_start || ((state == DRAIN) && (state_next == IDLE));
      inflight      <= issue;
      inflight_last <= final_issue;
      if (accept_start) begin
        addr      <= bus.base_addr;
        remaining <= bus.length;
      end else if (issue) begin
        addr       <= addr + ADDRESS_WIDTH'(1);
        remaining  <= remaining - (ADDRESS_WIDTH+1)'(1);
        raddr_hold <= addr;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stage p1 -> FIFO: memory data lands in the tail entry
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_dout;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end
endmodule
